// File: rtl/demux4_capture_chan_pkg.sv
// Shared constants, select encodings and channel state type for the 4-way capture demux.
// Optional overrun counters are enabled with DEMUX4_OVR_CNT_EN.
package demux4_pkg;

    localparam int NCH       = 4;
    localparam int OVR_CNT_W = 8;
    localparam logic [OVR_CNT_W-1:0] OVR_CNT_MAX = {OVR_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        CH0 = 2'b00,
        CH1 = 2'b01,
        CH2 = 2'b10,
        CH3 = 2'b11
    } chSel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chanState_t;

    // Selects are encoded identically to the mux side, so the channel index maps straight onto a one-hot strobe.
    function automatic logic [NCH-1:0] selToOneHot(input logic i_en, input logic [1:0] i_sel);
        logic [NCH-1:0] w_oneHot;
        case (chSel_t'(i_sel))
            CH0:     w_oneHot = 4'b0001;
            CH1:     w_oneHot = 4'b0010;
            CH2:     w_oneHot = 4'b0100;
            CH3:     w_oneHot = 4'b1000;
            default: w_oneHot = 4'b0000;
        endcase
        return i_en ? w_oneHot : {NCH{1'b0}};
    endfunction

endpackage

// File: rtl/demux4_capture_chan_if.sv
// Bus-side and consumer-side signals of the capture demux, grouped with driver/receiver modports.
// The ovr_cnt field exists only when DEMUX4_OVR_CNT_EN is defined.
interface demux4_capture_chan_if #(
    parameter int WIDTH = 1
);
    import demux4_pkg::*;

    logic [WIDTH-1:0] din;
    logic [1:0]       sel;
    logic             en;
    logic [NCH-1:0]   ack;
    logic             ovr_clr;

    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;
    logic [WIDTH-1:0] q3;
    logic [NCH-1:0]   valid;
    logic [NCH-1:0]   overrun;

`ifdef DEMUX4_OVR_CNT_EN
    logic [NCH*OVR_CNT_W-1:0] ovr_cnt;

    modport master (
        output din, sel, en, ack, ovr_clr,
        input  q0, q1, q2, q3, valid, overrun, ovr_cnt
    );

    modport slave (
        input  din, sel, en, ack, ovr_clr,
        output q0, q1, q2, q3, valid, overrun, ovr_cnt
    );
`else
    modport master (
        output din, sel, en, ack, ovr_clr,
        input  q0, q1, q2, q3, valid, overrun
    );

    modport slave (
        input  din, sel, en, ack, ovr_clr,
        output q0, q1, q2, q3, valid, overrun
    );
`endif

endinterface

// File: rtl/demux4_capture_chan_chan.sv
// One capture channel: holding register, EMPTY/FULL handshake state, sticky overrun flag
// and, with DEMUX4_OVR_CNT_EN, a saturating overrun counter.
module demux4_chan
    import demux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr,
    input  logic [WIDTH-1:0]     i_din,
    input  logic                 i_ack,
    input  logic                 i_ovrClr,
    output logic [WIDTH-1:0]     o_q,
    output logic                 o_valid,
    output logic                 o_overrun
`ifdef DEMUX4_OVR_CNT_EN
    ,
    output logic [OVR_CNT_W-1:0] o_ovrCnt
`endif
);

    chanState_t       r_state;
    chanState_t       w_nextState;
    logic             w_ovrEvent;
    logic [WIDTH-1:0] r_q;
    logic             r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // An ack only counts while FULL; a write that lands on unacknowledged data is the overrun event.
    always_comb begin
        w_nextState = r_state;
        w_ovrEvent  = 1'b0;
        case (r_state)
            EMPTY: begin
                if (i_wr) begin
                    w_nextState = FULL;
                end
            end
            FULL: begin
                if (i_wr) begin
                    w_nextState = FULL;
                    w_ovrEvent  = !i_ack;
                end else if (i_ack) begin
                    w_nextState = EMPTY;
                end
            end
            default: w_nextState = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_wr) begin
            r_q <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_ovrEvent) begin
            r_overrun <= 1'b1;
        end else if (i_ovrClr) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef DEMUX4_OVR_CNT_EN
    logic [OVR_CNT_W-1:0] r_ovrCnt;

    // A clear coinciding with an event restarts the count at one rather than zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovrCnt <= '0;
        end else if (i_ovrClr) begin
            r_ovrCnt <= w_ovrEvent ? OVR_CNT_W'(1) : '0;
        end else if (w_ovrEvent && (r_ovrCnt != OVR_CNT_MAX)) begin
            r_ovrCnt <= r_ovrCnt + OVR_CNT_W'(1);
        end
    end

    assign o_ovrCnt = r_ovrCnt;
`endif

    assign o_q       = r_q;
    assign o_valid   = (r_state == FULL);
    assign o_overrun = r_overrun;

endmodule

// File: rtl/demux4_capture_chan.sv
// Receive end of the shared 4:1 mux bus: decodes sel/en into four capture channels.
// Build with DEMUX4_OVR_CNT_EN to add the per-channel saturating overrun counters.
module demux4_capture_chan
    import demux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input logic                  clk,
    input logic                  rst,
    demux4_capture_chan_if.slave bus
);

    logic [NCH-1:0]            w_wrOneHot;
    logic [NCH-1:0][WIDTH-1:0] w_q;
    logic [NCH-1:0]            w_valid;
    logic [NCH-1:0]            w_overrun;
`ifdef DEMUX4_OVR_CNT_EN
    logic [NCH-1:0][OVR_CNT_W-1:0] w_ovrCnt;
`endif

    assign w_wrOneHot = selToOneHot(bus.en, bus.sel);

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        demux4_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_wr      (w_wrOneHot[k]),
            .i_din     (bus.din),
            .i_ack     (bus.ack[k]),
            .i_ovrClr  (bus.ovr_clr),
            .o_q       (w_q[k]),
            .o_valid   (w_valid[k]),
            .o_overrun (w_overrun[k])
`ifdef DEMUX4_OVR_CNT_EN
            ,
            .o_ovrCnt  (w_ovrCnt[k])
`endif
        );
    end

    assign bus.q0      = w_q[0];
    assign bus.q1      = w_q[1];
    assign bus.q2      = w_q[2];
    assign bus.q3      = w_q[3];
    assign bus.valid   = w_valid;
    assign bus.overrun = w_overrun;
`ifdef DEMUX4_OVR_CNT_EN
    assign bus.ovr_cnt = w_ovrCnt;
`endif

endmodule

// File: tb/tb_demux4_capture_chan.sv
// Scoreboard bench for demux4_capture_chan: directed scenarios plus random traffic against a
// transfer-level reference model; counter checks are active when DEMUX4_OVR_CNT_EN is defined.
module tb_demux4_capture_chan;

    localparam int W = 1;

    typedef struct packed {
        logic [3:0][W-1:0] q;
        logic [3:0]        valid;
        logic [3:0]        ovr;
        logic [3:0][7:0]   cnt;
    } exp_t;

    logic clk;
    logic rst;

    demux4_capture_chan_if #(.WIDTH(W)) bus ();

    demux4_capture_chan #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   vectorCount = 0;
    int   missCount   = 0;

    // Reference model: one entry per channel, updated per transfer rule
    logic [3:0][W-1:0] mQ;
    logic [3:0]        mValid;
    logic [3:0]        mOvr;
    int                mCnt[4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic iRst, input logic iEn, input logic [1:0] iSel,
                                 input logic [W-1:0] iDin, input logic [3:0] iAck, input logic iClr);
        exp_t e;
        @(negedge clk);
        rst         = iRst;
        bus.en      = iEn;
        bus.sel     = iSel;
        bus.din     = iDin;
        bus.ack     = iAck;
        bus.ovr_clr = iClr;
        for (int k = 0; k < 4; k++) begin
            bit hit;
            bit lost;
            hit  = iEn && (int'(iSel) == k);
            lost = hit && mValid[k] && !iAck[k];
            if (iRst) begin
                mQ[k] = '0;
                mValid[k] = 1'b0;
                mOvr[k] = 1'b0;
                mCnt[k] = 0;
            end else begin
                if (hit) mQ[k] = iDin;
                mValid[k] = hit || (mValid[k] && !iAck[k]);
                mOvr[k]   = lost || (mOvr[k] && !iClr);
                if (iClr) mCnt[k] = lost ? 1 : 0;
                else if (lost) mCnt[k] = (mCnt[k] + 1 > 255) ? 255 : mCnt[k] + 1;
            end
        end
        e.q     = mQ;
        e.valid = mValid;
        e.ovr   = mOvr;
        for (int k = 0; k < 4; k++) e.cnt[k] = 8'(mCnt[k]);
        sb.push_back(e);
    endtask

    // Monitor: every registered update is compared one tick after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("q0", 32'(bus.q0), 32'(e.q[0]));
                checkOutput("q1", 32'(bus.q1), 32'(e.q[1]));
                checkOutput("q2", 32'(bus.q2), 32'(e.q[2]));
                checkOutput("q3", 32'(bus.q3), 32'(e.q[3]));
                checkOutput("valid", 32'(bus.valid), 32'(e.valid));
                checkOutput("overrun", 32'(bus.overrun), 32'(e.ovr));
`ifdef DEMUX4_OVR_CNT_EN
                for (int k = 0; k < 4; k++) begin
                    checkOutput($sformatf("ovr_cnt%0d", k), 32'(bus.ovr_cnt[8*k +: 8]), 32'(e.cnt[k]));
                end
`endif
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.sel     = 2'b00;
        bus.din     = '0;
        bus.ack     = 4'b0000;
        bus.ovr_clr = 1'b0;
        mQ     = '0;
        mValid = '0;
        mOvr   = '0;
        for (int k = 0; k < 4; k++) mCnt[k] = 0;

        $display("[TB] reset and idle");
        repeat (2) applyStimulus(1, 0, 0, 0, 4'b0000, 0);
        repeat (5) applyStimulus(0, 0, 0, 0, 4'b0000, 0);

        $display("[TB] sequential fill");
        applyStimulus(0, 1, 2'd1, 1, 4'b0000, 0);
        applyStimulus(0, 1, 2'd2, 1, 4'b0000, 0);
        applyStimulus(0, 1, 2'd0, 0, 4'b0000, 0);
        applyStimulus(0, 1, 2'd3, 0, 4'b0000, 0);

        $display("[TB] handshake");
        applyStimulus(0, 0, 0, 0, 4'b0010, 0);
        applyStimulus(0, 0, 0, 0, 4'b0010, 0);
        applyStimulus(0, 0, 0, 0, 4'b0000, 0);

        $display("[TB] overrun and clear");
        applyStimulus(0, 0, 0, 0, 4'b0100, 0);
        applyStimulus(0, 1, 2'd2, 1, 4'b0000, 0);
        applyStimulus(0, 1, 2'd2, 0, 4'b0000, 0);
        applyStimulus(0, 0, 0, 0, 4'b0000, 1);
        applyStimulus(0, 1, 2'd2, 1, 4'b0000, 1);
        applyStimulus(0, 0, 0, 0, 4'b0000, 1);

        $display("[TB] simultaneous write and ack");
        applyStimulus(0, 1, 2'd3, 1, 4'b1000, 0);
        applyStimulus(0, 1, 2'd1, 1, 4'b0010, 0);

        $display("[TB] reset mid-operation");
        applyStimulus(0, 1, 2'd0, 1, 4'b0000, 0);
        applyStimulus(1, 1, 2'd0, 1, 4'b1111, 0);
        applyStimulus(0, 0, 0, 0, 4'b0000, 0);

        $display("[TB] saturation on channel 0");
        for (int i = 0; i < 301; i++) applyStimulus(0, 1, 2'd0, W'(i & 1), 4'b0000, 0);
        applyStimulus(0, 0, 0, 0, 4'b0000, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            logic rRst;
            logic rClr;
            rRst = ($urandom_range(0, 99) == 0);
            rClr = ($urandom_range(0, 19) == 0);
            applyStimulus(rRst, ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                          W'($urandom), 4'($urandom & $urandom), rClr);
        end
        applyStimulus(0, 0, 0, 0, 4'b0000, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            missCount++;
            $display("[TB] FAIL drain: got %0d pending entries expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/demux4_capture_chan.md
# demux4_capture_chan

Receive-side counterpart of the 4:1 decoder/tristate-buffer mux: takes the shared single-line bus plus its 2-bit select and enable, and demultiplexes each enabled transfer into one of four per-channel holding registers. Each channel presents its data with a valid/ack handshake to its consumer and flags overruns when a new transfer lands before the previous one was acknowledged. Sits at the far end of the shared mux bus, one per bus.

## Interface
- WIDTH, 1, bus data width; the current bus is 1 bit, and wider values are supported for reuse.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  shared bus data (mux output).
- sel  input  2  destination channel index, 0..3.
- en  input  1  transfer strobe; one transfer per cycle with en=1.
- ack  input  4  per-channel consumer acknowledge; ack[k] consumes channel k.
- ovr_clr  input  1  clears all sticky overrun flags.
- q0, q1, q2, q3  output  WIDTH  channel holding registers.
- valid  output  4  valid[k]=1 while q_k holds unconsumed data.
- overrun  output  4  sticky per-channel overrun flag.
- ovr_cnt  output  32  four 8-bit saturating overrun counters, channel k at bits [8k+7:8k]; present only with DEMUX4_OVR_CNT_EN.

## Operation
- Reset values: q0..q3=0, valid=0, overrun=0, ovr_cnt=0. Reset overrides every other input in the same cycle, including during an in-progress handshake.
- Decode: en=1 at an edge writes din into q_sel. No other channel is affected. en=0 leaves all q_k unchanged (hold, no bus drive implied).
- Per-channel state is two states, EMPTY (valid=0) and FULL (valid=1):
  - EMPTY + write -> FULL.
  - FULL + ack, no write -> EMPTY.
  - FULL + write + ack same cycle -> FULL with the new data; no overrun, because the ack consumed the old data.
  - FULL + write, no ack -> FULL with the new data overwriting the old (newest-wins); overrun[k] set.
  - EMPTY + ack -> ignored, stays EMPTY.
  - EMPTY + write + ack same cycle -> FULL; the ack is ignored, since valid was 0 when sampled.
- overrun[k] is sticky until ovr_clr=1 or rst. If ovr_clr and a new overrun event occur in the same cycle, the flag ends at 1 (the set wins).
- q_k is only written by a write to channel k. Ack does not clear q_k.

## Timing
- Write latency is one cycle: din/sel/en sampled at edge N; q_sel, valid and overrun are updated and visible after edge N.
- Ack is sampled at an edge; valid drops after that same edge. A consumer may hold ack high continuously, which yields single-cycle consumption.
- Back-to-back writes to different channels every cycle are fully supported, with no bubbles.
- sel is don't-care when en=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- DEMUX4_OVR_CNT_EN defined:
  - Adds the ovr_cnt port and four 8-bit counters.
  - Counter k increments on each overrun event on channel k and saturates at 255.
  - ovr_clr also zeroes the counters. If ovr_clr and an overrun event occur in the same cycle, the counter ends at 1.
- Undefined: no ovr_cnt port and no counters; the sticky overrun flags remain.

## Structure
- Package demux4_pkg holds:
  - NCH=4.
  - The select encodings CH0..CH3 = 2'b00..2'b11, matching the mux side.
  - The overrun counter width OVR_CNT_W=8 and its saturation value.
- Sub-module demux4_chan implements one channel: holding register, EMPTY/FULL state, overrun flag, and the optional counter. It takes a one-hot write enable (en && sel==k) and is instantiated four times.
- The top level contains only the 2-to-4 decode and output wiring.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then 5 idle cycles -> q0..q3=0, valid=4'b0000, overrun=4'b0000 throughout.
- Sequential fill: sel=1 din=1 en=1, then sel=2 din=1, then sel=0 din=0, then sel=3 din=0 on consecutive cycles, no acks -> after the 4th edge valid=4'b1111, q1=1, q2=1, q0=0, q3=0, overrun=0.
- Handshake: with channel 1 FULL, pulse ack=4'b0010 for one cycle -> valid[1]=0 after that edge, q1 still 1. A further ack[1] while empty -> no change.
- Overrun: write ch2 din=1, then ch2 din=0 with no ack -> q2=0, valid[2]=1, overrun=4'b0100. ovr_clr pulse -> overrun=0, and ovr_cnt[23:16]=0 when enabled.
- Simultaneous write+ack: ch3 FULL, en=1 sel=3 din=1 with ack[3]=1 -> q3=1, valid[3]=1, overrun[3]=0.
- Reset mid-operation and saturation:
  - Assert rst while en=1 and ack are active -> all outputs return to 0 next edge.
  - With DEMUX4_OVR_CNT_EN, 300 overrunning writes to ch0 -> ovr_cnt[7:0]=255.
